// File: rtl/phi_sequencer.sv
// Phi datapath sequencer: fetches FORMANTS T-value rows, issues them as spaced beats, then waits for and holds the result.
// Optional watchdog on the result wait is enabled by defining PHI_SEQ_WATCHDOG_EN.
module phi_sequencer #(
  parameter int BIT_WIDTH  = 32,
  parameter int FORMANTS   = 5,
  parameter int NU_VALUES  = 3,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 1023,
  localparam int KW = (FORMANTS > 1) ? $clog2(FORMANTS) : 1
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            frame_valid_in,
  output logic                            frame_ready_out,
  output logic [KW-1:0]                   tv_addr_out,
  input  logic [NU_VALUES*BIT_WIDTH-1:0]  tv_data_in,
  output logic                            phi_start_out,
  output logic                            phi_valid_out,
  output logic [NU_VALUES*BIT_WIDTH-1:0]  phi_tvals_out,
  input  logic [FORMANTS*BIT_WIDTH-1:0]   phi_data_in,
  input  logic                            phi_done_in,
  output logic [FORMANTS*BIT_WIDTH-1:0]   res_data_out,
  output logic                            res_valid_out,
  input  logic                            res_ready_in,
  output logic                            timeout_out,
  output logic [2:0]                      state_dbg_out
);

  // Handshakes: a frame is taken when frame_valid_in is high while frame_ready_out is high;
  // a result is released when res_ready_in is high while res_valid_out is high.
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FETCH, S_ISSUE, S_GAP, S_WAIT, S_HOLD
  } state_t;

  localparam int TW = NU_VALUES * BIT_WIDTH;
  localparam int RW = FORMANTS * BIT_WIDTH;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [KW-1:0] K_LAST = KW'(FORMANTS - 1);

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [KW-1:0] tv_addr_q, tv_addr_d;
  logic [TW-1:0] tvals_q, tvals_d;
  logic [RW-1:0] res_data_q, res_data_d;
  logic          phi_start_q, phi_start_d;
  logic          phi_valid_q, phi_valid_d;
  logic          res_valid_q, res_valid_d;
  logic          frame_ready_q, frame_ready_d;
  logic          advance;

`ifdef PHI_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wait_q, wait_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    gap_d      = gap_q;
    tvals_d    = tvals_q;
    res_data_d = res_data_q;
    phi_valid_d = 1'b0;
    advance    = 1'b0;
`ifdef PHI_SEQ_WATCHDOG_EN
    wait_d     = wait_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE:  if (frame_valid_in) state_d = S_START;
      S_START: begin
        k_d     = '0;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        tvals_d     = tv_data_in;
        phi_valid_d = 1'b1;
        if (GAP_CYCLES > 0) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          advance = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_LAST)) advance = 1'b1;
        else gap_d = gap_q + 1'b1;
      end
      S_WAIT: begin
        // A done arriving on the final watchdog cycle still wins over the abort.
        if (phi_done_in) begin
          res_data_d = phi_data_in;
          state_d    = S_HOLD;
        end
`ifdef PHI_SEQ_WATCHDOG_EN
        else if (wait_q == WW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else if (wait_q != '1) begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      S_HOLD:  if (res_ready_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (k_q == K_LAST) begin
        state_d = S_WAIT;
`ifdef PHI_SEQ_WATCHDOG_EN
        wait_d  = '0;
`endif
      end else begin
        k_d     = k_q + 1'b1;
        state_d = S_FETCH;
      end
    end

    // Outputs are registered views of the state being entered.
    tv_addr_d     = (state_d == S_FETCH) ? k_d : tv_addr_q;
    phi_start_d   = (state_d == S_START);
    res_valid_d   = (state_d == S_HOLD);
    frame_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      gap_q         <= '0;
      tv_addr_q     <= '0;
      tvals_q       <= '0;
      res_data_q    <= '0;
      phi_start_q   <= 1'b0;
      phi_valid_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      frame_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      gap_q         <= gap_d;
      tv_addr_q     <= tv_addr_d;
      tvals_q       <= tvals_d;
      res_data_q    <= res_data_d;
      phi_start_q   <= phi_start_d;
      phi_valid_q   <= phi_valid_d;
      res_valid_q   <= res_valid_d;
      frame_ready_q <= frame_ready_d;
    end
  end

`ifdef PHI_SEQ_WATCHDOG_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_out = timeout_q;
`else
  assign timeout_out = 1'b0;
`endif

  assign frame_ready_out = frame_ready_q;
  assign tv_addr_out     = tv_addr_q;
  assign phi_start_out   = phi_start_q;
  assign phi_valid_out   = phi_valid_q;
  assign phi_tvals_out   = tvals_q;
  assign res_data_out    = res_data_q;
  assign res_valid_out   = res_valid_q;
  assign state_dbg_out   = state_q;

endmodule

// File: tb/tb_phi_sequencer.sv
// Bench for phi_sequencer: default instance (GAP_CYCLES=2) plus a GAP_CYCLES=0 instance; watchdog checks when PHI_SEQ_WATCHDOG_EN is defined.
module tb_phi_sequencer;
  localparam int BW = 32;
  localparam int F  = 5;
  localparam int NU = 3;
  localparam int TW = NU * BW;
  localparam int RW = F * BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          frame_valid, frame_ready, phi_start, phi_valid, phi_done, res_valid, res_ready, timeout;
  logic [2:0]    tv_addr, st_dbg;
  logic [TW-1:0] tv_data, phi_tvals;
  logic [RW-1:0] phi_data, res_data;

  logic          frame_valid0, frame_ready0, phi_start0, phi_valid0, phi_done0, res_valid0, timeout0;
  logic [2:0]    tv_addr0, st_dbg0;
  logic [TW-1:0] tv_data0, phi_tvals0;
  logic [RW-1:0] phi_data0, res_data0;

  phi_sequencer dut (
    .clk_in(clk), .rst_in(rst), .frame_valid_in(frame_valid), .frame_ready_out(frame_ready),
    .tv_addr_out(tv_addr), .tv_data_in(tv_data), .phi_start_out(phi_start), .phi_valid_out(phi_valid),
    .phi_tvals_out(phi_tvals), .phi_data_in(phi_data), .phi_done_in(phi_done), .res_data_out(res_data),
    .res_valid_out(res_valid), .res_ready_in(res_ready), .timeout_out(timeout), .state_dbg_out(st_dbg)
  );

  phi_sequencer #(.GAP_CYCLES(0)) dut0 (
    .clk_in(clk), .rst_in(rst), .frame_valid_in(frame_valid0), .frame_ready_out(frame_ready0),
    .tv_addr_out(tv_addr0), .tv_data_in(tv_data0), .phi_start_out(phi_start0), .phi_valid_out(phi_valid0),
    .phi_tvals_out(phi_tvals0), .phi_data_in(phi_data0), .phi_done_in(phi_done0), .res_data_out(res_data0),
    .res_valid_out(res_valid0), .res_ready_in(1'b1), .timeout_out(timeout0), .state_dbg_out(st_dbg0)
  );

  function automatic logic [TW-1:0] row(input int k);
    return {32'(k), 32'(10 + k), 32'(20 + k)};
  endfunction

  function automatic logic [RW-1:0] res_word(input int base);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < F; i++) r = (r << BW) | RW'(base + i);
    return r;
  endfunction

  // Synchronous T-value tables: data for an address appears one cycle later.
  always @(posedge clk) tv_data  <= row(int'(tv_addr));
  always @(posedge clk) tv_data0 <= row(int'(tv_addr0));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [TW-1:0] exp_q[$];
  int            exp_t_q[$];
  int            exp_s_q[$];
  int            exp_to_q[$];
  logic [TW-1:0] exp0_q[$];
  int            exp0_t_q[$];
  int            exp0_s_q[$];
  logic [TW-1:0] last_tv = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (phi_start) begin
        check("start_expected", exp_s_q.size() > 0, 1);
        if (exp_s_q.size() > 0) check("start_cycle", cyc, exp_s_q.pop_front());
      end
      if (phi_valid) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          last_tv = exp_q.pop_front();
          check("beat_tvals", phi_tvals, last_tv);
          check("beat_cycle", cyc, exp_t_q.pop_front());
        end
      end else begin
        check("tvals_hold", phi_tvals, last_tv);
      end
      if (timeout) begin
        check("timeout_expected", exp_to_q.size() > 0, 1);
        if (exp_to_q.size() > 0) check("timeout_cycle", cyc, exp_to_q.pop_front());
      end
      if (phi_start0) begin
        check("start0_expected", exp0_s_q.size() > 0, 1);
        if (exp0_s_q.size() > 0) check("start0_cycle", cyc, exp0_s_q.pop_front());
      end
      if (phi_valid0) begin
        check("beat0_expected", exp0_q.size() > 0, 1);
        if (exp0_q.size() > 0) begin
          check("beat0_tvals", phi_tvals0, exp0_q.pop_front());
          check("beat0_cycle", cyc, exp0_t_q.pop_front());
        end
      end
      check("timeout0_never", timeout0, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_frame(output int t);
    t = cyc;
    exp_s_q.push_back(t + 1);
    for (int i = 0; i < F; i++) begin
      exp_q.push_back(row(i));
      exp_t_q.push_back(t + 4 + 4 * i);
    end
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    frame_valid = 0; phi_done = 0; phi_data = '0; res_ready = 0;
    frame_valid0 = 0; phi_done0 = 0; phi_data0 = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_phi_start", phi_start, 0);
    check("rst_phi_valid", phi_valid, 0);
    check("rst_phi_tvals", phi_tvals, 0);
    check("rst_tv_addr", tv_addr, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", frame_ready, 1);

    // Frame 1: nominal sequencing, ignored stray inputs, result hold.
    start_frame(t);
    check("ready_low_busy", frame_ready, 0);
    wait_until(t + 7);
    phi_done = 1'b1; phi_data = res_word(100); frame_valid = 1'b1;
    @(negedge clk);
    phi_done = 1'b0; phi_data = '0; frame_valid = 1'b0;
    wait_until(t + 20 + 600);
    check("no_result_before_done", res_valid, 0);
    phi_done = 1'b1; phi_data = res_word(1);
    @(negedge clk);
    phi_done = 1'b0; phi_data = '0;
    check("res_valid", res_valid, 1);
    check("res_data", res_data, res_word(1));
    check("ready_low_hold", frame_ready, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", res_valid, 1);
      check("hold_data", res_data, res_word(1));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_cleared", res_valid, 0);
    check("ready_after_accept", frame_ready, 1);
    check("frame1_beats_seen", exp_q.size(), 0);

    // Frame 2: no done at all.
    start_frame(t);
`ifdef PHI_SEQ_WATCHDOG_EN
    exp_to_q.push_back(t + 20 + 1 + 1023 + 1);
    wait_until(t + 20 + 1 + 1023);
    check("timeout_not_early", timeout, 0);
    @(negedge clk);
    check("timeout_pulse", timeout, 1);
    check("timeout_no_result", res_valid, 0);
    @(negedge clk);
    check("timeout_single", timeout, 0);
    check("ready_after_timeout", frame_ready, 1);
    check("res_data_kept", res_data, res_word(1));
    check("timeout_seen", exp_to_q.size(), 0);
`else
    wait_until(t + 1100);
    check("wait_persists_ready", frame_ready, 0);
    check("wait_persists_valid", res_valid, 0);
    phi_done = 1'b1; phi_data = res_word(7);
    @(negedge clk);
    phi_done = 1'b0; res_ready = 1'b1;
    check("late_res_valid", res_valid, 1);
    check("late_res_data", res_data, res_word(7));
    @(negedge clk);
    res_ready = 1'b0;
    check("late_res_cleared", res_valid, 0);
`endif
    check("frame2_beats_seen", exp_q.size(), 0);

    // Frame 3: asynchronous reset in the gap after the second beat.
    start_frame(t);
    wait_until(t + 9);
    #1 rst = 1'b1;
    #1;
    check("arst_phi_tvals", phi_tvals, 0);
    check("arst_tv_addr", tv_addr, 0);
    check("arst_phi_valid", phi_valid, 0);
    check("arst_phi_start", phi_start, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_res_data", res_data, 0);
    check("arst_timeout", timeout, 0);
    check("arst_ready", frame_ready, 1);
    exp_q.delete(); exp_t_q.delete(); exp_s_q.delete();
    last_tv = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_no_result", res_valid, 0);

    // Frame 4: restarts from row 0.
    start_frame(t);
    wait_until(t + 22);
    check("frame4_beats_seen", exp_q.size(), 0);
    check("frame4_no_result", res_valid, 0);

    // GAP_CYCLES=0 instance: back-to-back frames, ready tied high.
    t = cyc;
    exp0_s_q.push_back(t + 1);
    for (int i = 0; i < F; i++) begin
      exp0_q.push_back(row(i));
      exp0_t_q.push_back(t + 4 + 2 * i);
    end
    frame_valid0 = 1'b1;
    wait_until(t + 3);
    phi_done0 = 1'b1; phi_data0 = res_word(50);
    @(negedge clk);
    phi_done0 = 1'b0; phi_data0 = '0;
    wait_until(t + 14);
    check("g0_no_result_before_done", res_valid0, 0);
    phi_done0 = 1'b1; phi_data0 = res_word(1);
    exp0_s_q.push_back(t + 17);
    for (int i = 0; i < F; i++) begin
      exp0_q.push_back(row(i));
      exp0_t_q.push_back(t + 20 + 2 * i);
    end
    @(negedge clk);
    phi_done0 = 1'b0; phi_data0 = '0;
    check("g0_res_valid", res_valid0, 1);
    check("g0_res_data", res_data0, res_word(1));
    @(negedge clk);
    check("g0_res_accepted", res_valid0, 0);
    check("g0_ready_idle", frame_ready0, 1);
    @(negedge clk);
    frame_valid0 = 1'b0;
    wait_until(t + 30);
    check("g0_beats_seen", exp0_q.size(), 0);
    check("g0_starts_seen", exp0_s_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
